// File: rtl/sprite_line_fetcher_if.sv
// Bus bundle between the VGA side, the sprite ROM and sprite_line_fetcher.
// SPRITE_HFLIP_EN adds the per-line flip input.
interface sprite_line_fetcher_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              line_start;
  logic [9:0]        next_y;
  logic [9:0]        sprite_x;
  logic [9:0]        sprite_y;
  logic [ADDR_W-1:0] rom_addr;
  logic [23:0]       rom_color;
  logic [9:0]        draw_x;
  logic              pixel_valid;
  logic [23:0]       pixel_color;
  logic              busy;
  logic              done;
`ifdef SPRITE_HFLIP_EN
  logic              flip;

  modport slave (
    input  line_start, next_y, sprite_x, sprite_y, rom_color, draw_x, flip,
    output rom_addr, pixel_valid, pixel_color, busy, done
  );
  modport master (
    output line_start, next_y, sprite_x, sprite_y, rom_color, draw_x, flip,
    input  rom_addr, pixel_valid, pixel_color, busy, done
  );
`else
  modport slave (
    input  line_start, next_y, sprite_x, sprite_y, rom_color, draw_x,
    output rom_addr, pixel_valid, pixel_color, busy, done
  );
  modport master (
    output line_start, next_y, sprite_x, sprite_y, rom_color, draw_x,
    input  rom_addr, pixel_valid, pixel_color, busy, done
  );
`endif
endinterface

// File: rtl/sprite_line_fetcher.sv
// Fetches one sprite row into a line buffer during hblank and serves it by draw_x.
// Define SPRITE_HFLIP_EN to enable horizontal mirroring via bus.flip.
module sprite_line_fetcher #(
  parameter int unsigned SPR_W       = 21,
  parameter int unsigned SPR_H       = 21,
  parameter int unsigned ADDR_W      = 9,
  parameter logic [23:0] TRANSPARENT = 24'h800080
) (
  input logic                  Clk,
  input logic                  Reset,
  sprite_line_fetcher_if.slave bus
);

  localparam int unsigned ColW = $clog2(SPR_W);

  typedef enum logic [1:0] {StIdle, StFetch, StFlush} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [9:0]        xbase_q, xbase_d;
  logic              lv_q, lv_d;
  logic              done_q, done_d;
  logic              flip_q, flip_d;
  logic              pv_q, pv_d;
  logic [23:0]       pc_q, pc_d;
  logic [23:0]       buf_q [SPR_W];

  logic signed [10:0] row;
  logic               row_ok;
  logic               wr_en;
  logic [ColW-1:0]    wr_idx;
  logic [10:0]        dx;
  logic               hit;
  logic [23:0]        pix_c;

  assign row    = $signed({1'b0, bus.next_y}) - $signed({1'b0, bus.sprite_y});
  assign row_ok = !row[10] && (row[9:0] < 10'(SPR_H));

  // A line_start pulse takes priority in every state, which gives abort-and-restart.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    xbase_d = xbase_q;
    lv_d    = lv_q;
    flip_d  = flip_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    if (bus.line_start) begin
      lv_d = 1'b0;
      if (row_ok) begin
        state_d = StFetch;
        addr_d  = ADDR_W'(row[9:0] * SPR_W);
        col_d   = '0;
        xbase_d = bus.sprite_x;
`ifdef SPRITE_HFLIP_EN
        flip_d  = bus.flip;
`else
        flip_d  = 1'b0;
`endif
      end else begin
        state_d = StIdle;
      end
    end else begin
      case (state_q)
        StIdle: ;
        StFetch: begin
          wr_en = 1'b1;
          if (col_q == ColW'(SPR_W - 1)) begin
            state_d = StFlush;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            col_d  = col_q + ColW'(1);
          end
        end
        StFlush: begin
          lv_d    = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

`ifdef SPRITE_HFLIP_EN
  assign wr_idx = flip_q ? (ColW'(SPR_W - 1) - col_q) : col_q;
`else
  assign wr_idx = col_q;
`endif

  // 11-bit subtraction keeps x_base near 1023 from wrapping into a false hit.
  always_comb begin
    dx    = {1'b0, bus.draw_x} - {1'b0, xbase_q};
    hit   = lv_q && (bus.draw_x >= xbase_q) && (dx < 11'(SPR_W));
    pix_c = buf_q[dx[ColW-1:0]];
    pv_d  = hit && (pix_c != TRANSPARENT);
    pc_d  = pv_d ? pix_c : 24'h0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      col_q   <= '0;
      xbase_q <= '0;
      lv_q    <= 1'b0;
      done_q  <= 1'b0;
      flip_q  <= 1'b0;
      pv_q    <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      xbase_q <= xbase_d;
      lv_q    <= lv_d;
      done_q  <= done_d;
      flip_q  <= flip_d;
      pv_q    <= pv_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      buf_q[wr_idx] <= bus.rom_color;
    end
  end

  assign bus.rom_addr    = addr_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.pixel_valid = pv_q;
  assign bus.pixel_color = pc_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Bench for sprite_line_fetcher: directed checks plus random traffic against a line-level model.
module tb_sprite_line_fetcher;

  localparam int SprW = 21;
  localparam int SprH = 21;
  localparam int AW   = 9;
  localparam logic [23:0] Transp = 24'h800080;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flip_in;

  sprite_line_fetcher_if #(.ADDR_W(AW)) bus ();

  sprite_line_fetcher dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_fn(input int a);
    if (a % 5 == 3) return Transp;
    return {8'h10 + 8'(a), 8'(a >> 8), 8'hA5 ^ 8'(a)};
  endfunction

  assign bus.rom_color = rom_fn(int'(bus.rom_addr));

`ifdef SPRITE_HFLIP_EN
  assign flip_in = bus.flip;
`else
  assign flip_in = 1'b0;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line-level model: a fetch is an age counter; the buffer is just the ROM row.
  bit          started = 0;
  int          age     = -1;
  bit          m_lv    = 0;
  int          m_xbase = 0;
  int          m_base  = 0;
  bit          m_flip  = 0;
  int          e_addr  = 0;
  bit          e_busy  = 0;
  bit          e_done  = 0;
  bit          e_pv    = 0;
  logic [23:0] e_pc    = '0;

  always @(posedge clk) begin
    int dx, row, idx;
    logic [23:0] c;
    if (rst) begin
      started = 1;
      age     = -1;
      m_lv    = 0;
      e_addr  = 0;
      e_busy  = 0;
      e_done  = 0;
      e_pv    = 0;
      e_pc    = '0;
    end else begin
      dx   = int'(bus.draw_x) - m_xbase;
      e_pv = 0;
      e_pc = '0;
      if (m_lv && dx >= 0 && dx < SprW) begin
        idx = m_flip ? (SprW - 1 - dx) : dx;
        c   = rom_fn(m_base + idx);
        if (c != Transp) begin
          e_pv = 1;
          e_pc = c;
        end
      end
      e_done = 0;
      if (bus.line_start) begin
        m_lv = 0;
        row  = int'(bus.next_y) - int'(bus.sprite_y);
        if (row >= 0 && row < SprH) begin
          age     = 0;
          m_base  = row * SprW;
          m_xbase = int'(bus.sprite_x);
          m_flip  = flip_in;
        end else begin
          age = -1;
        end
      end else if (age >= 0) begin
        age++;
        if (age == SprW + 1) begin
          age    = -1;
          m_lv   = 1;
          e_done = 1;
        end
      end
      if (age >= 0) e_addr = m_base + ((age < SprW - 1) ? age : SprW - 1);
      e_busy = (age >= 0);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("rom_addr", 32'(bus.rom_addr), 32'(e_addr));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("pixel_valid", 32'(bus.pixel_valid), 32'(e_pv));
      chk("pixel_color", 32'(bus.pixel_color), 32'(e_pc));
    end
  end

  task automatic pulse(input int ny, input int sy, input int sx);
    bus.next_y     = 10'(ny);
    bus.sprite_y   = 10'(sy);
    bus.sprite_x   = 10'(sx);
    bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
  endtask

  initial begin
    int ndone, nvalid, at, sx, sy, t;
    bus.line_start = 1'b0;
    bus.next_y     = '0;
    bus.sprite_x   = '0;
    bus.sprite_y   = '0;
    bus.draw_x     = '0;
`ifdef SPRITE_HFLIP_EN
    bus.flip       = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_pixel_valid", 32'(bus.pixel_valid), 0);
    chk("reset_pixel_color", 32'(bus.pixel_color), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_rom_addr", 32'(bus.rom_addr), 0);
    chk("reset_done", 32'(bus.done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Row 5 fetch: addresses 105..125, done 22 cycles after line_start.
    pulse(105, 100, 200);
    for (int k = 0; k < 22; k++) begin
      chk("addr_seq", 32'(bus.rom_addr), (k <= 20) ? 32'(105 + k) : 32'd125);
      chk("busy_during", 32'(bus.busy), 1);
      chk("done_early", 32'(bus.done), 0);
      @(negedge clk);
    end
    chk("done_at_22", 32'(bus.done), 1);
    chk("busy_after", 32'(bus.busy), 0);

    for (int x = 190; x <= 230; x++) begin
      bus.draw_x = 10'(x);
      @(negedge clk);
      if (x == 200) begin
        chk("px200_valid", 32'(bus.pixel_valid), 1);
        chk("px200_color", 32'(bus.pixel_color), 32'(rom_fn(105)));
      end
      if (x == 199 || x == 221) chk("edge_invalid", 32'(bus.pixel_valid), 0);
    end

    // Rows just outside the sprite: no fetch at all.
    for (int j = 0; j < 2; j++) begin
      pulse((j == 0) ? 99 : 121, 100, 200);
      ndone  = 0;
      nvalid = 0;
      for (int k = 0; k < 30; k++) begin
        bus.draw_x = 10'(195 + k);
        @(negedge clk);
        if (bus.done) ndone++;
        if (bus.pixel_valid) nvalid++;
      end
      chk("oor_done", 32'(ndone), 0);
      chk("oor_valid", 32'(nvalid), 0);
    end

    // Restart 10 cycles into a fetch with row 3.
    pulse(105, 100, 200);
    repeat (9) @(negedge clk);
    pulse(103, 100, 200);
    chk("abort_addr", 32'(bus.rom_addr), 63);
    ndone = 0;
    at    = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (ndone == 1) at = k;
      end
    end
    chk("abort_latency", 32'(at), 22);
    chk("abort_ndone", 32'(ndone), 1);

`ifdef SPRITE_HFLIP_EN
    bus.flip = 1'b1;
    pulse(50, 50, 300);
    repeat (23) @(negedge clk);
    bus.draw_x = 10'd300;
    @(negedge clk);
    chk("flip_left", 32'(bus.pixel_color), 32'(rom_fn(20)));
    bus.draw_x = 10'd320;
    @(negedge clk);
    chk("flip_right", 32'(bus.pixel_color), 32'(rom_fn(0)));
    bus.flip = 1'b0;
`endif

    // Random traffic including near-1023 columns, restarts and resets.
    sx = 200;
    sy = 100;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 24) == 0) begin
        sy = int'($urandom_range(0, 1023));
        sx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 1023))
                                         : int'($urandom_range(0, 1023));
        t  = sy + int'($urandom_range(0, 30)) - 4;
        bus.next_y     = 10'(t & 1023);
        bus.sprite_y   = 10'(sy);
        bus.sprite_x   = 10'(sx);
`ifdef SPRITE_HFLIP_EN
        bus.flip       = 1'($urandom_range(0, 1));
`endif
        bus.line_start = 1'b1;
      end else begin
        bus.line_start = 1'b0;
      end
      t = sx + int'($urandom_range(0, 30)) - 5;
      bus.draw_x = 10'(t & 1023);
      @(negedge clk);
    end
    rst            = 1'b0;
    bus.line_start = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
